// File: rtl/store_drain_buffer_pkg.sv
// Shared sizing constants and drain FSM encodings for the store drain buffer.
// Pure declarations; no logic.
// Imported by the top and the forwarding matcher.
package store_drain_buffer_pkg;

  localparam int SB_NUM   = 4;
  localparam int SB_SEL   = 2;
  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;
  localparam int STRB_LEN = DATA_LEN / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

endpackage

// File: rtl/sb_fwd_match.sv
// Age-ordered store-to-load forwarding select over the buffer entries.
// Purely combinational; the youngest valid word-address match wins.
// Partial-strobe winners report a stall instead of data.
module sb_fwd_match
  import store_drain_buffer_pkg::*;
(
  input  logic [SB_NUM-1:0]   ent_valid,
  input  logic [ADDR_LEN-3:0] ent_word  [SB_NUM],
  input  logic [DATA_LEN-1:0] ent_data  [SB_NUM],
  input  logic [STRB_LEN-1:0] ent_wstrb [SB_NUM],
  input  logic [SB_SEL-1:0]   head,
  input  logic [ADDR_LEN-3:0] ld_word,
  output logic                fwd_hit,
  output logic [DATA_LEN-1:0] fwd_data,
  output logic                fwd_stall
);

  logic              found;
  logic [SB_SEL-1:0] idx;
  logic [SB_SEL-1:0] win;

  // Walk from oldest (head) to youngest; later matches override earlier ones.
  always_comb begin
    found = 1'b0;
    win   = head;
    idx   = head;
    for (int i = 0; i < SB_NUM; i++) begin
      idx = head + SB_SEL'(i);
      if (ent_valid[idx] && (ent_word[idx] == ld_word)) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Only a fully-written word can be forwarded; anything partial blocks the load.
  always_comb begin
    fwd_hit   = found && (&ent_wstrb[win]);
    fwd_stall = found && !(&ent_wstrb[win]);
    fwd_data  = fwd_hit ? ent_data[win] : '0;
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer: two-wide in-order enqueue, one-at-a-time memory drain.
// Drain is req/ready then write-ack; a new request is raised the cycle after an ack.
// commit_ready drops once fewer than two free slots remain; commits are then dropped.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                commit_valid_1,
  input  logic                commit_valid_2,
  input  logic [ADDR_LEN-1:0] commit_addr_1,
  input  logic [ADDR_LEN-1:0] commit_addr_2,
  input  logic [DATA_LEN-1:0] commit_data_1,
  input  logic [DATA_LEN-1:0] commit_data_2,
  input  logic [STRB_LEN-1:0] commit_wstrb_1,
  input  logic [STRB_LEN-1:0] commit_wstrb_2,
  output logic                commit_ready,
  output logic                mem_req_valid,
  output logic [ADDR_LEN-1:0] mem_req_addr,
  output logic [DATA_LEN-1:0] mem_req_data,
  output logic [STRB_LEN-1:0] mem_req_wstrb,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  input  logic [ADDR_LEN-1:0] ld_addr,
  output logic                fwd_hit,
  output logic [DATA_LEN-1:0] fwd_data,
  output logic                fwd_stall,
  output logic [SB_SEL:0]     sb_count,
  output logic                sb_empty
);

  localparam logic [SB_SEL:0] CNT_ONE   = (SB_SEL + 1)'(1);
  localparam logic [SB_SEL:0] READY_MAX = (SB_SEL + 1)'(SB_NUM - 2);

  logic [1:0]          state_q, state_d;
  logic [SB_SEL-1:0]   head_q, head_d, tail_q, tail_d, slot_2;
  logic [SB_SEL:0]     count_q, count_d, enq_num;
  logic [SB_NUM-1:0]   valid_q, valid_d;
  logic [ADDR_LEN-1:0] addr_q  [SB_NUM];
  logic [ADDR_LEN-1:0] addr_d  [SB_NUM];
  logic [DATA_LEN-1:0] data_q  [SB_NUM];
  logic [DATA_LEN-1:0] data_d  [SB_NUM];
  logic [STRB_LEN-1:0] wstrb_q [SB_NUM];
  logic [STRB_LEN-1:0] wstrb_d [SB_NUM];
  logic [ADDR_LEN-3:0] ent_word [SB_NUM];
  logic                wr_1, wr_2, pop;

  assign commit_ready  = (count_q <= READY_MAX);
  assign sb_count      = count_q;
  assign sb_empty      = (count_q == '0) && (state_q == ST_IDLE);
  assign mem_req_addr  = addr_q[head_q];
  assign mem_req_data  = data_q[head_q];
  assign mem_req_wstrb = wstrb_q[head_q];

  // Accepted commits; a lone younger store takes the tail slot itself.
  always_comb begin
    wr_1    = commit_ready && commit_valid_1;
    wr_2    = commit_ready && commit_valid_2;
    enq_num = (SB_SEL + 1)'(wr_1) + (SB_SEL + 1)'(wr_2);
    slot_2  = tail_q + SB_SEL'(wr_1);
  end

  // Drain FSM: IDLE only notices entries already registered in count_q.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    mem_req_valid = (state_q == ST_REQ);
    case (state_q)
      ST_IDLE: if (count_q != '0) state_d = ST_REQ;
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_resp_valid) begin
          pop     = 1'b1;
          state_d = ((count_q + enq_num) != CNT_ONE) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry array and pointer updates; pop and enqueue never touch the same slot.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wstrb_d = wstrb_q;
    if (pop) valid_d[head_q] = 1'b0;
    if (wr_1) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = commit_addr_1;
      data_d[tail_q]  = commit_data_1;
      wstrb_d[tail_q] = commit_wstrb_1;
    end
    if (wr_2) begin
      valid_d[slot_2] = 1'b1;
      addr_d[slot_2]  = commit_addr_2;
      data_d[slot_2]  = commit_data_2;
      wstrb_d[slot_2] = commit_wstrb_2;
    end
    head_d  = head_q + SB_SEL'(pop);
    tail_d  = tail_q + enq_num[SB_SEL-1:0];
    count_d = count_q + enq_num - (SB_SEL + 1)'(pop);
  end

  // Word addresses for the forwarding compare.
  always_comb begin
    for (int i = 0; i < SB_NUM; i++) ent_word[i] = addr_q[i][ADDR_LEN-1:2];
  end

  // Control state; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q and needs no reset.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    data_q  <= data_d;
    wstrb_q <= wstrb_d;
  end

  sb_fwd_match u_fwd (
    .ent_valid (valid_q),
    .ent_word  (ent_word),
    .ent_data  (data_q),
    .ent_wstrb (wstrb_q),
    .head      (head_q),
    .ld_word   (ld_addr[ADDR_LEN-1:2]),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .fwd_stall (fwd_stall)
  );

endmodule

// File: tb/tb_store_drain_buffer.sv
module tb_store_drain_buffer;

  logic        clk, reset;
  logic        commit_valid_1, commit_valid_2;
  logic [31:0] commit_addr_1, commit_addr_2, commit_data_1, commit_data_2;
  logic [3:0]  commit_wstrb_1, commit_wstrb_2;
  logic        commit_ready, mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_data, ld_addr, fwd_data;
  logic [3:0]  mem_req_wstrb;
  logic        fwd_hit, fwd_stall, sb_empty;
  logic [2:0]  sb_count;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  ent_t mq[$];
  int   ph = 0;

  store_drain_buffer dut (
    .clk(clk), .reset(reset),
    .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
    .commit_addr_1(commit_addr_1), .commit_addr_2(commit_addr_2),
    .commit_data_1(commit_data_1), .commit_data_2(commit_data_2),
    .commit_wstrb_1(commit_wstrb_1), .commit_wstrb_2(commit_wstrb_2),
    .commit_ready(commit_ready),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_wstrb(mem_req_wstrb),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_stall(fwd_stall), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, want completion");
    $fatal(1);
  end

  // Protocol assertion: commits must never be offered while the buffer is not ready.
  always @(posedge clk) begin
    if (!reset && (commit_valid_1 || commit_valid_2)) begin
      compared++;
      assert (commit_ready) else begin
        $display("FAIL commit_protocol commit offered with commit_ready=0, want 1");
        mismatched++;
      end
    end
  end

  // Reference model: FIFO of stores plus a three-phase drain (idle/request/await-ack).
  task automatic step();
    int sz, en;
    sz = mq.size();
    en = 0;
    if (reset) begin
      mq.delete();
      ph = 0;
    end else begin
      if (sz <= 2) en = int'(commit_valid_1) + int'(commit_valid_2);
      case (ph)
        0: if (sz > 0) ph = 1;
        1: if (mem_req_ready) ph = 2;
        default: if (mem_resp_valid) begin
          void'(mq.pop_front());
          ph = (sz - 1 + en > 0) ? 1 : 0;
        end
      endcase
      if (sz <= 2) begin
        if (commit_valid_1) mq.push_back(ent_t'{commit_addr_1, commit_data_1, commit_wstrb_1});
        if (commit_valid_2) mq.push_back(ent_t'{commit_addr_2, commit_data_2, commit_wstrb_2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_c1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    commit_valid_1 = 1'b1; commit_addr_1 = a; commit_data_1 = d; commit_wstrb_1 = s;
  endtask

  task automatic set_c2(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    commit_valid_2 = 1'b1; commit_addr_2 = a; commit_data_2 = d; commit_wstrb_2 = s;
  endtask

  task automatic clr_c();
    commit_valid_1 = 1'b0; commit_valid_2 = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!mem_req_valid && n < 20) begin step(); n++; end
    compared++;
    if (mem_req_valid !== 1'b1) begin
      $display("FAIL %s_req_timeout mem_req_valid=%b after %0d cycles, want 1", nm, mem_req_valid, n);
      mismatched++;
    end
  endtask

  task automatic accept_ack();
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); reset = 1'b0;
    compared += 6;
    if (sb_count !== 3'd0) begin $display("FAIL rst_count got %0d want 0", sb_count); mismatched++; end
    if (mem_req_valid !== 1'b0) begin $display("FAIL rst_req_valid got %b want 0", mem_req_valid); mismatched++; end
    if (fwd_hit !== 1'b0) begin $display("FAIL rst_fwd_hit got %b want 0", fwd_hit); mismatched++; end
    if (fwd_stall !== 1'b0) begin $display("FAIL rst_fwd_stall got %b want 0", fwd_stall); mismatched++; end
    if (sb_empty !== 1'b1) begin $display("FAIL rst_empty got %b want 1", sb_empty); mismatched++; end
    if (commit_ready !== 1'b1) begin $display("FAIL rst_ready got %b want 1", commit_ready); mismatched++; end
  endtask

  task automatic test_single_store();
    set_c1(32'h100, 32'hDEADBEEF, 4'hF); step(); clr_c();
    compared += 2;
    if (sb_count !== 3'd1) begin $display("FAIL single_count got %0d want 1", sb_count); mismatched++; end
    if (mem_req_valid !== 1'b0) begin $display("FAIL single_idle_lag got %b want 0", mem_req_valid); mismatched++; end
    step();
    for (int i = 0; i < 4; i++) begin
      compared += 4;
      if (mem_req_valid !== 1'b1) begin $display("FAIL single_valid[%0d] got %b want 1", i, mem_req_valid); mismatched++; end
      if (mem_req_addr !== 32'h100) begin $display("FAIL single_addr[%0d] got %h want 00000100", i, mem_req_addr); mismatched++; end
      if (mem_req_data !== 32'hDEADBEEF) begin $display("FAIL single_data[%0d] got %h want deadbeef", i, mem_req_data); mismatched++; end
      if (mem_req_wstrb !== 4'hF) begin $display("FAIL single_wstrb[%0d] got %h want f", i, mem_req_wstrb); mismatched++; end
      if (i < 3) step();
    end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    compared += 2;
    if (mem_req_valid !== 1'b0) begin $display("FAIL single_wait_valid got %b want 0", mem_req_valid); mismatched++; end
    if (sb_empty !== 1'b0) begin $display("FAIL single_wait_empty got %b want 0", sb_empty); mismatched++; end
    mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0;
    compared += 2;
    if (sb_empty !== 1'b1) begin $display("FAIL single_done_empty got %b want 1", sb_empty); mismatched++; end
    if (sb_count !== 3'd0) begin $display("FAIL single_done_count got %0d want 0", sb_count); mismatched++; end
  endtask

  task automatic test_wrap_dual();
    // head=tail=1 here; two more stores bring tail to 3.
    set_c1(32'h0, 32'h0, 4'hF); set_c2(32'h4, 32'h4, 4'hF); step(); clr_c();
    wait_req("wrap_pre0"); accept_ack();
    wait_req("wrap_pre1"); accept_ack();
    set_c1(32'h10, 32'hA0A0A0A0, 4'hF); set_c2(32'h14, 32'hB1B1B1B1, 4'hF); step(); clr_c();
    compared++;
    if (sb_count !== 3'd2) begin $display("FAIL wrap_count2 got %0d want 2", sb_count); mismatched++; end
    wait_req("wrap_first");
    compared++;
    if (mem_req_addr !== 32'h10) begin $display("FAIL wrap_first_addr got %h want 00000010", mem_req_addr); mismatched++; end
    accept_ack();
    compared++;
    if (sb_count !== 3'd1) begin $display("FAIL wrap_count1 got %0d want 1", sb_count); mismatched++; end
    wait_req("wrap_second");
    compared += 2;
    if (mem_req_addr !== 32'h14) begin $display("FAIL wrap_second_addr got %h want 00000014", mem_req_addr); mismatched++; end
    if (mem_req_data !== 32'hB1B1B1B1) begin $display("FAIL wrap_second_data got %h want b1b1b1b1", mem_req_data); mismatched++; end
    accept_ack();
    compared++;
    if (sb_count !== 3'd0) begin $display("FAIL wrap_count0 got %0d want 0", sb_count); mismatched++; end
  endtask

  task automatic test_fill();
    logic [31:0] exp_a [3];
    exp_a[0] = 32'h30C; exp_a[1] = 32'h310; exp_a[2] = 32'h314;
    set_c1(32'h300, 32'h1, 4'hF); set_c2(32'h304, 32'h2, 4'hF); step(); clr_c();
    compared += 2;
    if (sb_count !== 3'd2) begin $display("FAIL fill_count2 got %0d want 2", sb_count); mismatched++; end
    if (commit_ready !== 1'b1) begin $display("FAIL fill_ready2 got %b want 1", commit_ready); mismatched++; end
    set_c1(32'h308, 32'h3, 4'hF); set_c2(32'h30C, 32'h4, 4'hF); step(); clr_c();
    compared += 2;
    if (sb_count !== 3'd4) begin $display("FAIL fill_count4 got %0d want 4", sb_count); mismatched++; end
    if (commit_ready !== 1'b0) begin $display("FAIL fill_ready4 got %b want 0", commit_ready); mismatched++; end
    wait_req("fill_a");
    compared++;
    if (mem_req_addr !== 32'h300) begin $display("FAIL fill_addr_a got %h want 00000300", mem_req_addr); mismatched++; end
    accept_ack();
    compared += 2;
    if (sb_count !== 3'd3) begin $display("FAIL fill_count3 got %0d want 3", sb_count); mismatched++; end
    if (commit_ready !== 1'b0) begin $display("FAIL fill_ready3 got %b want 0", commit_ready); mismatched++; end
    wait_req("fill_b"); accept_ack();
    wait_req("fill_c");
    compared++;
    if (mem_req_addr !== 32'h308) begin $display("FAIL fill_addr_c got %h want 00000308", mem_req_addr); mismatched++; end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    set_c1(32'h310, 32'h5, 4'hF); set_c2(32'h314, 32'h6, 4'hF);
    step(); mem_resp_valid = 1'b0; clr_c();
    compared++;
    if (sb_count !== 3'd3) begin $display("FAIL fill_resp_enq_count got %0d want 3", sb_count); mismatched++; end
    for (int i = 0; i < 3; i++) begin
      wait_req("fill_tail");
      compared++;
      if (mem_req_addr !== exp_a[i]) begin $display("FAIL fill_order[%0d] got %h want %h", i, mem_req_addr, exp_a[i]); mismatched++; end
      accept_ack();
    end
  endtask

  task automatic test_forwarding();
    set_c1(32'h200, 32'h11111111, 4'hF); set_c2(32'h200, 32'h22222222, 4'hF);
    ld_addr = 32'h202; #1;
    compared++;
    if (fwd_hit !== 1'b0) begin $display("FAIL fwd_same_cycle got %b want 0", fwd_hit); mismatched++; end
    step(); clr_c();
    compared += 3;
    if (fwd_hit !== 1'b1) begin $display("FAIL fwd_hit got %b want 1", fwd_hit); mismatched++; end
    if (fwd_data !== 32'h22222222) begin $display("FAIL fwd_youngest got %h want 22222222", fwd_data); mismatched++; end
    if (fwd_stall !== 1'b0) begin $display("FAIL fwd_nostall got %b want 0", fwd_stall); mismatched++; end
    ld_addr = 32'h204; #1;
    compared += 3;
    if (fwd_hit !== 1'b0) begin $display("FAIL fwd_miss_hit got %b want 0", fwd_hit); mismatched++; end
    if (fwd_stall !== 1'b0) begin $display("FAIL fwd_miss_stall got %b want 0", fwd_stall); mismatched++; end
    if (fwd_data !== 32'h0) begin $display("FAIL fwd_miss_data got %h want 0", fwd_data); mismatched++; end
    set_c1(32'h200, 32'h00003333, 4'h3); step(); clr_c();
    ld_addr = 32'h200; #1;
    compared += 3;
    if (fwd_stall !== 1'b1) begin $display("FAIL fwd_partial_stall got %b want 1", fwd_stall); mismatched++; end
    if (fwd_hit !== 1'b0) begin $display("FAIL fwd_partial_hit got %b want 0", fwd_hit); mismatched++; end
    if (fwd_data !== 32'h0) begin $display("FAIL fwd_partial_data got %h want 0", fwd_data); mismatched++; end
    for (int i = 0; i < 2; i++) begin wait_req("fwd_drain"); accept_ack(); end
    wait_req("fwd_last");
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    compared++;
    if (fwd_stall !== 1'b1) begin $display("FAIL fwd_inflight_stall got %b want 1", fwd_stall); mismatched++; end
    mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0;
    compared++;
    if (fwd_stall !== 1'b0) begin $display("FAIL fwd_after_drain got %b want 0", fwd_stall); mismatched++; end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    logic [31:0] exp_a;
    set_c1(32'h500, 32'h5, 4'hF); set_c2(32'h504, 32'h6, 4'hF); step(); clr_c();
    set_c1(32'h508, 32'h7, 4'hF); step(); clr_c();
    wait_req("b2b");
    for (int i = 0; i < 6; i++) begin
      exp_v = ((i % 2) == 0);
      exp_a = 32'h500 + 32'(4 * (i / 2));
      compared++;
      if (mem_req_valid !== exp_v) begin $display("FAIL b2b_valid[%0d] got %b want %b", i, mem_req_valid, exp_v); mismatched++; end
      if (exp_v) begin
        compared++;
        if (mem_req_addr !== exp_a) begin $display("FAIL b2b_addr[%0d] got %h want %h", i, mem_req_addr, exp_a); mismatched++; end
      end
      mem_req_ready = exp_v;
      mem_resp_valid = !exp_v;
      step();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    compared += 2;
    if (sb_count !== 3'd0) begin $display("FAIL b2b_count got %0d want 0", sb_count); mismatched++; end
    if (sb_empty !== 1'b1) begin $display("FAIL b2b_empty got %b want 1", sb_empty); mismatched++; end
  endtask

  task automatic test_reset_in_wait();
    set_c1(32'h600, 32'h8, 4'hF); set_c2(32'h604, 32'h9, 4'hF); step(); clr_c();
    wait_req("rstw");
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    compared += 2;
    if (mem_req_valid !== 1'b0) begin $display("FAIL rstw_in_wait got %b want 0", mem_req_valid); mismatched++; end
    if (sb_count !== 3'd2) begin $display("FAIL rstw_pre_count got %0d want 2", sb_count); mismatched++; end
    reset = 1'b1; step(); reset = 1'b0;
    compared += 3;
    if (sb_count !== 3'd0) begin $display("FAIL rstw_count got %0d want 0", sb_count); mismatched++; end
    if (mem_req_valid !== 1'b0) begin $display("FAIL rstw_valid got %b want 0", mem_req_valid); mismatched++; end
    if (sb_empty !== 1'b1) begin $display("FAIL rstw_empty got %b want 1", sb_empty); mismatched++; end
    mem_resp_valid = 1'b1; step(); mem_resp_valid = 1'b0; step();
    compared += 2;
    if (sb_count !== 3'd0) begin $display("FAIL rstw_late_resp_count got %0d want 0", sb_count); mismatched++; end
    if (mem_req_valid !== 1'b0) begin $display("FAIL rstw_late_resp_valid got %b want 0", mem_req_valid); mismatched++; end
  endtask

  task automatic test_random();
    logic        e_hit, e_stall, found;
    logic [31:0] e_data;
    int          sz;
    for (int cyc = 0; cyc < 800; cyc++) begin
      clr_c();
      if (mq.size() <= 2) begin
        if ($urandom_range(0, 2) == 0)
          set_c1(32'h700 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        if ($urandom_range(0, 2) == 0)
          set_c2(32'h700 + 32'($urandom_range(0, 3) * 4), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end
      mem_req_ready  = ($urandom_range(0, 1) == 1);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      ld_addr        = 32'h700 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
      #1;
      sz = mq.size();
      found = 1'b0; e_hit = 1'b0; e_stall = 1'b0; e_data = 32'h0;
      for (int i = sz - 1; i >= 0 && !found; i--) begin
        if (mq[i].a[31:2] == ld_addr[31:2]) begin
          found = 1'b1;
          e_hit = (mq[i].s == 4'hF);
          e_stall = !e_hit;
          e_data = e_hit ? mq[i].d : 32'h0;
        end
      end
      compared += 7;
      if (sb_count !== 3'(sz)) begin $display("FAIL rnd_count cyc %0d got %0d want %0d", cyc, sb_count, sz); mismatched++; end
      if (commit_ready !== (sz <= 2)) begin $display("FAIL rnd_ready cyc %0d got %b want %b", cyc, commit_ready, (sz <= 2)); mismatched++; end
      if (sb_empty !== (sz == 0 && ph == 0)) begin $display("FAIL rnd_empty cyc %0d got %b want %b", cyc, sb_empty, (sz == 0 && ph == 0)); mismatched++; end
      if (mem_req_valid !== (ph == 1)) begin $display("FAIL rnd_req_valid cyc %0d got %b want %b", cyc, mem_req_valid, (ph == 1)); mismatched++; end
      if (fwd_hit !== e_hit) begin $display("FAIL rnd_fwd_hit cyc %0d got %b want %b", cyc, fwd_hit, e_hit); mismatched++; end
      if (fwd_stall !== e_stall) begin $display("FAIL rnd_fwd_stall cyc %0d got %b want %b", cyc, fwd_stall, e_stall); mismatched++; end
      if (fwd_data !== e_data) begin $display("FAIL rnd_fwd_data cyc %0d got %h want %h", cyc, fwd_data, e_data); mismatched++; end
      if (ph == 1 && sz > 0) begin
        compared++;
        if ({mem_req_addr, mem_req_data, mem_req_wstrb} !== {mq[0].a, mq[0].d, mq[0].s}) begin
          $display("FAIL rnd_req_payload cyc %0d got %h/%h/%h want %h/%h/%h", cyc,
                   mem_req_addr, mem_req_data, mem_req_wstrb, mq[0].a, mq[0].d, mq[0].s);
          mismatched++;
        end
      end
      step();
    end
    clr_c(); mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_c();
    commit_addr_1 = '0; commit_addr_2 = '0; commit_data_1 = '0; commit_data_2 = '0;
    commit_wstrb_1 = '0; commit_wstrb_2 = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; ld_addr = '0;
    @(posedge clk); #1;
    test_reset();
    test_single_store();
    test_wrap_dual();
    test_fill();
    test_forwarding();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
Post-commit store buffer downstream of the store queue. Accepts up to two retired stores per cycle in program order, holds them in a FIFO, and drains them one at a time to the data-memory write port over a valid/ready request plus write-ack handshake. Provides combinational store-to-load forwarding for loads that hit buffered stores, and a drained indication for fences.

Parameters:
SB_NUM, 4, buffer entries (power of two, >=2)
SB_SEL, 2, log2(SB_NUM)
ADDR_LEN, 32, address width
DATA_LEN, 32, data width; strobe width is DATA_LEN/8

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
commit_valid_1  in  1  older retired store present
commit_valid_2  in  1  younger retired store present
commit_addr_1/_2  in  ADDR_LEN  store byte address
commit_data_1/_2  in  DATA_LEN  store data, lane-aligned
commit_wstrb_1/_2  in  DATA_LEN/8  byte enables
commit_ready  out  1  room for two entries
mem_req_valid  out  1  write request to memory
mem_req_addr  out  ADDR_LEN  head entry address
mem_req_data  out  DATA_LEN  head entry data
mem_req_wstrb  out  DATA_LEN/8  head entry strobes
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  write acknowledged
ld_addr  in  ADDR_LEN  load lookup address
fwd_hit  out  1  full-word forward available
fwd_data  out  DATA_LEN  forwarded word
fwd_stall  out  1  youngest match is partial; load must retry
sb_count  out  SB_SEL+1  occupied entries
sb_empty  out  1  buffer empty and FSM idle

Behaviour:
- Reset (synchronous, one edge): head=tail=0, count=0, state IDLE, all entry valid bits 0. Outputs after reset: mem_req_valid=0, fwd_hit=0, fwd_stall=0, sb_empty=1, commit_ready=1. Reset during REQ/WAIT abandons the transaction; the memory side is reset on the same signal.
- commit_ready = (count <= SB_NUM-2), combinational from registered count.
- Enqueue only when commit_ready. Entry 1 is written at tail, entry 2 at tail+1. If only valid_2 is set, it is written at tail. Tail advances by the number of valid entries, with natural modulo-SB_NUM wrap.
- A commit_valid while !commit_ready is a protocol violation; it is ignored and flagged by a bench assertion.
- FSM IDLE: when count!=0, move to REQ. New entries are not visible to IDLE until the cycle after they are written.
- FSM REQ: mem_req_valid=1, with addr/data/wstrb driven from the head entry. Addr/data/wstrb are stable while valid and !ready. On mem_req_ready, move to WAIT.
- FSM WAIT: mem_req_valid=0. On mem_resp_valid, pop head (clear valid, head+1). Next state is REQ if (count - 1 + same-cycle enqueues) > 0, else IDLE.
- mem_resp_valid outside WAIT is ignored.
- Count update: count <= count + enq_num - pop, with enq_num in 0..2 and pop in 0..1, all in the same cycle. count never exceeds SB_NUM.
- Forwarding (combinational):
  - Compare ld_addr[ADDR_LEN-1:2] against every valid entry, including the in-flight head.
  - Youngest match (closest to tail) wins.
  - If the winner's wstrb is all ones: fwd_hit=1, fwd_data=winner data.
  - Otherwise: fwd_stall=1, fwd_hit=0, fwd_data=0.
  - If no match: all forwarding outputs are 0.
  - Entries being written this cycle are not visible.
- sb_empty = (count==0) && (state==IDLE).

Decomposition:
- Shared constants header: SB_NUM, SB_SEL, FSM state encodings (IDLE=0, REQ=1, WAIT=2).
- One sub-module, sb_fwd_match: combinational age-ordered match/priority select over the entry arrays, taking head as the age origin.

Test Plan:
- Single store: commit_1 addr 0x100 data 0xDEADBEEF wstrb F -> REQ next cycle, mem_req_addr=0x100. Hold mem_req_ready=0 for 3 cycles -> outputs stable. Then ready, then resp -> sb_empty=1.
- Dual commit at tail=3 (wrap): addr 0x10/0x14 -> entries land in slots 3 and 0. Drain order 0x10 then 0x14. sb_count goes 2,1,0.
- Fill: 4 entries, memory stalled -> commit_ready=0 at count 3 and 4. Resp with same-cycle dual enqueue at count 2 -> count goes to 3.
- Forwarding: entries 0x200=0x11111111 (older) and 0x200=0x22222222 (younger) -> ld_addr 0x202 gives fwd_hit=1, fwd_data=0x22222222. Younger entry with wstrb 0x3 -> fwd_stall=1.
- Back-to-back drain: 3 entries, ready and resp each asserted the cycle after the request -> no IDLE bubble between requests; mem_req_valid pattern 1,0,1,0,1,0.
- Reset in WAIT with count=2 -> next cycle count=0, mem_req_valid=0. A later mem_resp_valid is ignored.
